commit_trace_arbiter: RTL and testbench

- Shares one trace output stream among the NR_PORTS commit ports of the core.
- Each cycle it captures every retiring (non-excepting) instruction record and timestamps it with a free-running cycle counter.
- Records are buffered in a shared FIFO in program order (port 0 before port 1 …) and drained one per cycle over a valid/ready interface to a trace sink (file writer, DMA, or debug module).
- It back-pressures commit with a stall hint and counts records lost to overflow.

---
 rtl/commit_trace_arbiter.sv | 165 ++++++++++++++++
 tb/tb_commit_trace_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_arbiter.sv
// commit_trace_arbiter: collects retiring instruction records from all commit
// ports. Each record is timestamped with a free-running cycle counter and
// buffered in a shared first-word-fall-through FIFO. The FIFO drains one
// record per cycle to a trace sink over valid/ready. Records that do not fit
// are counted in a saturating drop counter.
module commit_trace_arbiter #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned VLEN     = 39,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NR_PORTS-1:0]      commit_valid_i,
  input  logic [NR_PORTS*VLEN-1:0] commit_pc_i,
  input  logic [NR_PORTS*32-1:0]   commit_instr_i,
  input  logic [NR_PORTS*5-1:0]    commit_rd_i,
  input  logic [NR_PORTS-1:0]      commit_fp_i,
  input  logic [NR_PORTS*XLEN-1:0] commit_wdata_i,
  input  logic [1:0]               priv_lvl_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [63:0]              trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [4:0]               trace_rd_o,
  output logic                     trace_fp_o,
  output logic [XLEN-1:0]          trace_wdata_o,
  output logic [1:0]               trace_priv_o,
  output logic [31:0]              trace_cycle_o,
  output logic                     stall_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CNT_W + CW;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]    STALL_TH = CW'(DEPTH - NR_PORTS);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [VLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [4:0]      r_rd    [DEPTH];
  logic            r_fp    [DEPTH];
  logic [XLEN-1:0] r_wdata [DEPTH];
  logic [1:0]      r_priv  [DEPTH];
  logic [31:0]     r_stamp [DEPTH];

  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_cycle;
  logic             r_stall;
  logic [CNT_W-1:0] r_dropCnt;

  logic [CW-1:0]    w_free;
  logic [CW-1:0]    w_pushN;
  logic [CW-1:0]    w_dropN;
  logic [NR_PORTS-1:0] w_push;
  logic [PW-1:0]    w_slot [NR_PORTS];
  logic             w_pop;
  logic [CW-1:0]    w_countNext;
  logic [SW-1:0]    w_dropSum;
  logic [CNT_W-1:0] w_dropNext;

  // Scan valid ports oldest-first, handing out free slots in order and counting the overflow.
  always_comb begin
    w_free  = DEPTH_C - r_count;
    w_pushN = '0;
    w_dropN = '0;
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      w_push[i] = 1'b0;
      w_slot[i] = r_wptr;
      if (commit_valid_i[i]) begin
        if (w_pushN < w_free) begin
          w_push[i] = 1'b1;
          w_slot[i] = r_wptr + w_pushN[PW-1:0];
          w_pushN   = w_pushN + CW'(1);
        end else begin
          w_dropN = w_dropN + CW'(1);
        end
      end
    end
  end

  // Pop handshake, next occupancy and saturating drop total.
  always_comb begin
    w_pop       = (r_count != '0) && trace_ready_i;
    w_countNext = r_count + w_pushN - CW'(w_pop);
    w_dropSum   = SW'(r_dropCnt) + SW'(w_dropN);
    w_dropNext  = (w_dropSum > SW'(DROP_MAX)) ? DROP_MAX : w_dropSum[CNT_W-1:0];
  end

  // Pointers, occupancy, stall hint and drop counter; a flush discards this cycle's traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_stall   <= 1'b0;
      r_dropCnt <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
    end else begin
      r_rptr    <= r_rptr + PW'(w_pop);
      r_wptr    <= r_wptr + w_pushN[PW-1:0];
      r_count   <= w_countNext;
      r_stall   <= (w_countNext > STALL_TH);
      r_dropCnt <= w_dropNext;
    end
  end

  // Record storage; each accepted port writes its own distinct slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        r_pc[e]    <= '0;
        r_instr[e] <= '0;
        r_rd[e]    <= '0;
        r_fp[e]    <= 1'b0;
        r_wdata[e] <= '0;
        r_priv[e]  <= '0;
        r_stamp[e] <= '0;
      end
    end else if (!flush_i) begin
      for (int i = 0; i < int'(NR_PORTS); i++) begin
        if (w_push[i]) begin
          r_pc[w_slot[i]]    <= commit_pc_i[i*VLEN +: VLEN];
          r_instr[w_slot[i]] <= commit_instr_i[i*32 +: 32];
          r_rd[w_slot[i]]    <= commit_rd_i[i*5 +: 5];
          r_fp[w_slot[i]]    <= commit_fp_i[i];
          r_wdata[w_slot[i]] <= commit_wdata_i[i*XLEN +: XLEN];
          r_priv[w_slot[i]]  <= priv_lvl_i;
          r_stamp[w_slot[i]] <= r_cycle;
        end
      end
    end
  end

  // Free-running timestamp counter, untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign trace_valid_o = (r_count != '0);
  assign trace_pc_o    = 64'(r_pc[r_rptr]);
  assign trace_instr_o = r_instr[r_rptr];
  assign trace_rd_o    = r_rd[r_rptr];
  assign trace_fp_o    = r_fp[r_rptr];
  assign trace_wdata_o = r_wdata[r_rptr];
  assign trace_priv_o  = r_priv[r_rptr];
  assign trace_cycle_o = r_stamp[r_rptr];
  assign stall_o       = r_stall;
  assign drop_cnt_o    = r_dropCnt;

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Testbench for commit_trace_arbiter: directed scenarios plus randomized
// traffic, compared each cycle against a queue-based reference model.
module tb_commit_trace_arbiter;

  localparam int NR = 2;
  localparam int VL = 39;
  localparam int XL = 64;
  localparam int DP = 8;
  localparam int CW = 3;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i;
  logic [NR-1:0]    commit_valid_i;
  logic [NR*VL-1:0] commit_pc_i;
  logic [NR*32-1:0] commit_instr_i;
  logic [NR*5-1:0]  commit_rd_i;
  logic [NR-1:0]    commit_fp_i;
  logic [NR*XL-1:0] commit_wdata_i;
  logic [1:0]       priv_lvl_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [63:0]      trace_pc_o;
  logic [31:0]      trace_instr_o;
  logic [4:0]       trace_rd_o;
  logic             trace_fp_o;
  logic [XL-1:0]    trace_wdata_o;
  logic [1:0]       trace_priv_o;
  logic [31:0]      trace_cycle_o;
  logic             stall_o;
  logic [CW-1:0]    drop_cnt_o;

  // 10-unit clock period.
  always #5 clk_i = ~clk_i;

  commit_trace_arbiter #(
    .NR_PORTS(NR), .VLEN(VL), .XLEN(XL), .DEPTH(DP), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_i(commit_rd_i),
    .commit_fp_i(commit_fp_i), .commit_wdata_i(commit_wdata_i),
    .priv_lvl_i(priv_lvl_i), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
    .trace_instr_o(trace_instr_o), .trace_rd_o(trace_rd_o),
    .trace_fp_o(trace_fp_o), .trace_wdata_o(trace_wdata_o),
    .trace_priv_o(trace_priv_o), .trace_cycle_o(trace_cycle_o),
    .stall_o(stall_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        fp;
    logic [63:0] wdata;
    logic [1:0]  priv;
    logic [31:0] cyc;
  } recT;

  recT         modelQ[$];
  logic [31:0] modelCycle;
  int          modelDrop;
  logic        modelStall;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic rdy, input logic fl, input logic [VL-1:0] basePc);
    commit_valid_i = v;
    trace_ready_i  = rdy;
    flush_i        = fl;
    priv_lvl_i     = 2'($urandom_range(0, 3));
    for (int i = 0; i < NR; i++) begin
      commit_pc_i[i*VL +: VL]    = (basePc != '0) ? basePc + VL'(4 * i) : VL'({$urandom, $urandom});
      commit_instr_i[i*32 +: 32] = $urandom;
      commit_rd_i[i*5 +: 5]      = 5'($urandom_range(0, 31));
      commit_fp_i[i]             = 1'($urandom_range(0, 1));
      commit_wdata_i[i*XL +: XL] = {$urandom, $urandom};
    end
  endtask

  task automatic checkState();
    checkOutput("valid", 64'(trace_valid_o), 64'(modelQ.size() != 0));
    checkOutput("stall", 64'(stall_o), 64'(modelStall));
    checkOutput("drops", 64'(drop_cnt_o), 64'(modelDrop));
    if (modelQ.size() != 0) begin
      checkOutput("pc",    trace_pc_o,            modelQ[0].pc);
      checkOutput("instr", 64'(trace_instr_o),    64'(modelQ[0].instr));
      checkOutput("rd",    64'(trace_rd_o),       64'(modelQ[0].rd));
      checkOutput("fp",    64'(trace_fp_o),       64'(modelQ[0].fp));
      checkOutput("wdata", 64'(trace_wdata_o),    modelQ[0].wdata);
      checkOutput("priv",  64'(trace_priv_o),     64'(modelQ[0].priv));
      checkOutput("stamp", 64'(trace_cycle_o),    64'(modelQ[0].cyc));
    end
  endtask

  task automatic checkReset();
    checkOutput("rstValid", 64'(trace_valid_o), 64'd0);
    checkOutput("rstPc",    trace_pc_o,         64'd0);
    checkOutput("rstInstr", 64'(trace_instr_o), 64'd0);
    checkOutput("rstRd",    64'(trace_rd_o),    64'd0);
    checkOutput("rstFp",    64'(trace_fp_o),    64'd0);
    checkOutput("rstWdata", trace_wdata_o,      64'd0);
    checkOutput("rstPriv",  64'(trace_priv_o),  64'd0);
    checkOutput("rstStamp", 64'(trace_cycle_o), 64'd0);
    checkOutput("rstStall", 64'(stall_o),       64'd0);
    checkOutput("rstDrops", 64'(drop_cnt_o),    64'd0);
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelCycle = '0;
    modelDrop  = 0;
    modelStall = 1'b0;
  endtask

  // Reference behaviour for one clock edge, using the inputs held during the cycle.
  task automatic modelStep();
    recT r;
    int  free;
    int  taken;
    logic doPop;
    if (flush_i) begin
      modelQ.delete();
      modelStall = 1'b0;
    end else begin
      free  = DP - modelQ.size();
      doPop = (modelQ.size() != 0) && trace_ready_i;
      taken = 0;
      for (int i = 0; i < NR; i++) begin
        if (commit_valid_i[i]) begin
          if (taken < free) begin
            r.pc    = 64'(commit_pc_i[i*VL +: VL]);
            r.instr = commit_instr_i[i*32 +: 32];
            r.rd    = commit_rd_i[i*5 +: 5];
            r.fp    = commit_fp_i[i];
            r.wdata = commit_wdata_i[i*XL +: XL];
            r.priv  = priv_lvl_i;
            r.cyc   = modelCycle;
            modelQ.push_back(r);
            taken++;
          end else if (modelDrop < DROP_MAX) begin
            modelDrop++;
          end
        end
      end
      if (doPop) void'(modelQ.pop_front());
      modelStall = (modelQ.size() > DP - NR);
    end
    modelCycle = modelCycle + 32'd1;
  endtask

  task automatic runCycle(input logic [NR-1:0] v, input logic rdy, input logic fl, input logic [VL-1:0] basePc);
    applyStimulus(v, rdy, fl, basePc);
    @(negedge clk_i);
    checkState();
    @(posedge clk_i);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    commit_valid_i = '0;
    trace_ready_i  = 1'b0;
    flush_i        = 1'b0;
    priv_lvl_i     = '0;
    commit_pc_i    = '0;
    commit_instr_i = '0;
    commit_rd_i    = '0;
    commit_fp_i    = '0;
    commit_wdata_i = '0;
  endtask

  initial begin
    idleInputs();
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1 checkReset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    modelReset();

    // Idle cycles 0..4, then both ports retire in cycle 5 and drain.
    repeat (5) runCycle(2'b00, 1'b1, 1'b0, '0);
    runCycle(2'b11, 1'b1, 1'b0, VL'(39'h80000000));
    repeat (3) runCycle(2'b00, 1'b1, 1'b0, '0);

    // Fill with no sink, overflow, then pop-and-drop on a full FIFO.
    repeat (4) runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b01, 1'b1, 1'b0, '0);
    runCycle(2'b10, 1'b1, 1'b0, '0);

    // Occupancy 7 then both ports valid: one fits, one dropped.
    runCycle(2'b00, 1'b0, 1'b1, '0);
    repeat (3) runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b01, 1'b0, 1'b0, '0);
    runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b00, 1'b0, 1'b0, '0);

    // Occupancy 5 then flush with traffic present.
    runCycle(2'b00, 1'b0, 1'b1, '0);
    runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b11, 1'b0, 1'b0, '0);
    runCycle(2'b10, 1'b0, 1'b0, '0);
    runCycle(2'b11, 1'b1, 1'b1, '0);
    repeat (2) runCycle(2'b00, 1'b0, 1'b0, '0);

    // Drive the drop counter into saturation.
    repeat (8) runCycle(2'b11, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    checkOutput("dropSat", 64'(drop_cnt_o), 64'(DROP_MAX));
    @(posedge clk_i);
    modelStep();
    #1;

    // Reset mid-stream: everything clears at once.
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 checkReset();
    idleInputs();
    modelReset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (6) runCycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0);

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      runCycle(2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), '0);
    end

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
